// File: rtl/half_adder.sv
// Single-bit half adder: combinational sum/carry, registered copies of both,
// and a saturating count of clock edges on which the carry was set.
module half_adder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    output logic             suma,
    output logic             acarreo,
    output logic             suma_q,
    output logic             acarreo_q,
    output logic [CNT_W-1:0] carry_cnt
);

    assign suma    = A ^ B;
    assign acarreo = A & B;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suma_q    <= 1'b0;
            acarreo_q <= 1'b0;
            carry_cnt <= '0;
        end else begin
            suma_q    <= suma;
            acarreo_q <= acarreo;
            // Holds at all ones rather than wrapping.
            if (acarreo && (carry_cnt != '1))
                carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Directed, table-driven bench for half_adder; a second instance with a
// 2-bit counter covers saturation.
module tb_half_adder;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       suma, acarreo, suma_q, acarreo_q;
    logic [7:0] carry_cnt;
    logic       suma2, acarreo2, suma_q2, acarreo_q2;
    logic [1:0] carry_cnt2;

    int unsigned n_pass;
    int unsigned n_total;

    half_adder #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B),
        .suma(suma), .acarreo(acarreo),
        .suma_q(suma_q), .acarreo_q(acarreo_q),
        .carry_cnt(carry_cnt)
    );

    half_adder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B),
        .suma(suma2), .acarreo(acarreo2),
        .suma_q(suma_q2), .acarreo_q(acarreo_q2),
        .carry_cnt(carry_cnt2)
    );

    // Clock only toggles once enabled, so the first sweep runs with it idle.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clk     = 1'b0;
        clk_en  = 1'b0;
        rst_n   = 1'b0;
        A       = 1'b0;
        B       = 1'b0;

        vecs[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        vecs[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        vecs[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        vecs[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        #1;
        check("rst_suma_q",     32'(suma_q),     0);
        check("rst_acarreo_q",  32'(acarreo_q),  0);
        check("rst_carry_cnt",  32'(carry_cnt),  0);
        check("rst_carry_cnt2", 32'(carry_cnt2), 0);

        // Combinational sweep with clock idle and reset asserted.
        for (int i = 0; i < 4; i++) begin
            A = vecs[i].a;
            B = vecs[i].b;
            #10;
            check($sformatf("sweep_suma[%0d]", i),    32'(suma),    32'(vecs[i].s));
            check($sformatf("sweep_acarreo[%0d]", i), 32'(acarreo), 32'(vecs[i].c));
            check($sformatf("sweep_suma2[%0d]", i),   32'(suma2),   32'(vecs[i].s));
        end
        check("sweep_regs_held", 32'({suma_q, acarreo_q}), 0);

        // Release reset between edges, then pipeline 01 -> 11.
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        A = 1'b0; B = 1'b1;
        @(posedge clk); #1;
        check("pipe1_suma_q",    32'(suma_q),    1);
        check("pipe1_acarreo_q", 32'(acarreo_q), 0);
        check("pipe1_cnt",       32'(carry_cnt), 0);
        A = 1'b1; B = 1'b1;
        @(posedge clk); #1;
        check("pipe2_suma_q",    32'(suma_q),    0);
        check("pipe2_acarreo_q", 32'(acarreo_q), 1);
        check("pipe2_cnt",       32'(carry_cnt), 1);

        // Asynchronous reset mid-cycle with AB = 11.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_suma_q",    32'(suma_q),    0);
        check("arst_acarreo_q", 32'(acarreo_q), 0);
        check("arst_cnt",       32'(carry_cnt), 0);
        check("arst_acarreo",   32'(acarreo),   1);
        @(posedge clk); #1;
        check("arst_hold_acarreo_q", 32'(acarreo_q), 0);
        check("arst_hold_cnt",       32'(carry_cnt), 0);
        check("arst_hold_acarreo",   32'(acarreo),   1);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter: 5 edges with carry, then 3 without.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("cnt_up[%0d]", i), 32'(carry_cnt), 32'(i + 1));
        end
        A = 1'b1; B = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("cnt_hold[%0d]", i), 32'(carry_cnt), 5);
        end
        check("cnt_hold_suma_q",    32'(suma_q),    1);
        check("cnt_hold_acarreo_q", 32'(acarreo_q), 0);

        // Saturation on the 2-bit instance.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("sat_rst_cnt2", 32'(carry_cnt2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        A = 1'b1; B = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("sat_cnt2[%0d]", i), 32'(carry_cnt2), (i + 1 > 3) ? 3 : 32'(i + 1));
            check($sformatf("sat_cnt8[%0d]", i), 32'(carry_cnt),  32'(i + 1));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("sat_clear_cnt2", 32'(carry_cnt2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Toggle A between edges with B = 1.
        A = 1'b0; B = 1'b1;
        @(posedge clk); #1;
        check("glitch_q0", 32'(suma_q), 1);
        A = 1'b1; #1;
        check("glitch_suma_a1", 32'(suma),   0);
        check("glitch_q_a1",    32'(suma_q), 1);
        A = 1'b0; #1;
        check("glitch_suma_a0", 32'(suma),   1);
        check("glitch_q_a0",    32'(suma_q), 1);
        A = 1'b1; #1;
        check("glitch_suma_a1b", 32'(suma),   0);
        check("glitch_q_a1b",    32'(suma_q), 1);
        @(posedge clk); #1;
        check("glitch_q_edge",       32'(suma_q),    0);
        check("glitch_acarreo_edge", 32'(acarreo_q), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
